// File: rtl/dmem_lsu.sv
// Word-organised byte-lane data memory with a load/store unit for the MEM stage.
// One access is outstanding at a time: IDLE accepts, ACCESS reads or writes
// the array, RESP holds the result until the consumer takes it.
// A request presented in cycle n produces rsp_valid in cycle n+2.
module dmem_lsu #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned WORD_W = ADDR_W - 2;
  localparam int unsigned DEPTH  = 1 << WORD_W;
  localparam int unsigned LANES  = 4;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic [1:0]          off_c;
  logic [WORD_W-1:0]   word_idx_c;
  logic                illegal_c;
  logic                misalign_c;
  logic                err_c;
  logic [LANES-1:0]    be_c;
  logic [DATA_W-1:0]   wdata_lane_c;
  logic [DATA_W-1:0]   shifted_c;
  logic [DATA_W-1:0]   load_c;
  logic                mem_we_c;

  // Decode legality, store lane steering and load extraction from the captured request
  always_comb begin
    off_c        = addr_q[1:0];
    word_idx_c   = addr_q[ADDR_W-1:2];
    illegal_c    = 1'b1;
    misalign_c   = 1'b0;
    be_c         = 4'b1111;
    load_c       = '0;

    case (funct3_q)
      3'b000, 3'b001, 3'b010: illegal_c = 1'b0;
      3'b100, 3'b101:         illegal_c = we_q;
      default:                illegal_c = 1'b1;
    endcase

    case (funct3_q[1:0])
      2'b01:   misalign_c = addr_q[0];
      2'b10:   misalign_c = (off_c != 2'b00);
      default: misalign_c = 1'b0;
    endcase

    err_c = illegal_c | misalign_c;

    case (funct3_q[1:0])
      2'b00:   be_c = 4'b0001 << off_c;
      2'b01:   be_c = 4'b0011 << off_c;
      default: be_c = 4'b1111;
    endcase

    wdata_lane_c = wdata_q << {off_c, 3'b000};
    shifted_c    = mem_q[word_idx_c] >> {off_c, 3'b000};

    case (funct3_q)
      3'b000:  load_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
      3'b001:  load_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
      3'b100:  load_c = {24'b0, shifted_c[7:0]};
      3'b101:  load_c = {16'b0, shifted_c[15:0]};
      default: load_c = shifted_c;
    endcase

    // Reset in ACCESS must not let a pending store land
    mem_we_c = (state_q == S_ACCESS) && we_q && !err_c && !reset;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d        = req_we;
          funct3_d    = req_funct3;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          req_ready_d = 1'b0;
          state_d     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = err_c;
        rsp_rdata_d = (!we_q && !err_c) ? load_c : '0;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // Control and request-capture registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Byte-enable write into the (unreset) memory array
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < int'(LANES); b++) begin
        if (be_c[b]) begin
          mem_q[word_idx_c][8*b +: 8] <= wdata_lane_c[8*b +: 8];
        end
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: vector table plus handwritten corner sequences,
// with expected responses queued when a request is driven and checked on rsp_valid.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int acc_cyc;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    string       name;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];

  dmem_lsu #(.ADDR_W(9), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [8:0] a,
                              input logic [31:0] wd, input logic [31:0] rd,
                              input logic er, input string nm);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rd; v.err = er; v.name = nm;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive_req(input vec_t v);
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    req_valid  = 1'b1;
  endtask

  // Queue the expectation, present the request and wait (bounded) for acceptance
  task automatic send(input vec_t v);
    bit accepted;
    bit ready_seen;
    int pres;
    accepted = 1'b0;
    pres = cyc;
    sb_q.push_back(v);
    drive_req(v);
    for (int i = 0; i < 20 && !accepted; i++) begin
      ready_seen = req_ready;
      pres = cyc;
      @(posedge clk); #1;
      if (ready_seen) accepted = 1'b1;
    end
    req_valid = 1'b0;
    acc_cyc = pres;
    chk({v.name, " accepted"}, 32'(accepted), 32'd1);
  endtask

  // Wait (bounded) for a response, compare with the queue head, complete the handshake
  task automatic collect(input bit chk_lat);
    vec_t e;
    for (int i = 0; i < 20 && !rsp_valid; i++) begin
      @(posedge clk); #1;
    end
    if (!rsp_valid) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: got rsp_valid=0 expected 1 within 20 cycles");
    end else if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty: got unexpected response rdata=0x%08h", rsp_rdata);
      @(posedge clk); #1;
    end else begin
      e = sb_q.pop_front();
      chk({e.name, " rdata"}, rsp_rdata, e.rdata);
      chk({e.name, " err"}, 32'(rsp_err), 32'(e.err));
      if (chk_lat) chk({e.name, " latency"}, 32'(cyc - acc_cyc), 32'd2);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int prev_acc;

    vecs.push_back(mk(1, 3'b010, 9'h010, 32'hDEADBEEF, 32'h0, 0, "sw_010"));
    vecs.push_back(mk(0, 3'b010, 9'h010, 32'h0, 32'hDEADBEEF, 0, "lw_010"));
    vecs.push_back(mk(1, 3'b010, 9'h020, 32'h00000000, 32'h0, 0, "sw_020"));
    vecs.push_back(mk(1, 3'b000, 9'h023, 32'h12345680, 32'h0, 0, "sb_023"));
    vecs.push_back(mk(0, 3'b010, 9'h020, 32'h0, 32'h80000000, 0, "lw_020"));
    vecs.push_back(mk(0, 3'b000, 9'h023, 32'h0, 32'hFFFFFF80, 0, "lb_023"));
    vecs.push_back(mk(0, 3'b100, 9'h023, 32'h0, 32'h00000080, 0, "lbu_023"));
    vecs.push_back(mk(1, 3'b000, 9'h021, 32'h000000A5, 32'h0, 0, "sb_021"));
    vecs.push_back(mk(0, 3'b010, 9'h020, 32'h0, 32'h8000A500, 0, "lw_020b"));
    vecs.push_back(mk(1, 3'b010, 9'h030, 32'h11111111, 32'h0, 0, "sw_030"));
    vecs.push_back(mk(1, 3'b001, 9'h032, 32'h0000F00D, 32'h0, 0, "sh_032"));
    vecs.push_back(mk(0, 3'b010, 9'h030, 32'h0, 32'hF00D1111, 0, "lw_030"));
    vecs.push_back(mk(0, 3'b001, 9'h032, 32'h0, 32'hFFFFF00D, 0, "lh_032"));
    vecs.push_back(mk(0, 3'b101, 9'h032, 32'h0, 32'h0000F00D, 0, "lhu_032"));
    vecs.push_back(mk(0, 3'b001, 9'h030, 32'h0, 32'h00001111, 0, "lh_030"));
    vecs.push_back(mk(0, 3'b000, 9'h031, 32'h0, 32'h00000011, 0, "lb_031"));
    vecs.push_back(mk(1, 3'b010, 9'h040, 32'hAAAAAAAA, 32'h0, 0, "sw_040"));
    vecs.push_back(mk(1, 3'b010, 9'h041, 32'h55555555, 32'h0, 1, "sw_041_mis"));
    vecs.push_back(mk(1, 3'b001, 9'h041, 32'h55555555, 32'h0, 1, "sh_041_mis"));
    vecs.push_back(mk(1, 3'b011, 9'h040, 32'h55555555, 32'h0, 1, "st_f3_011"));
    vecs.push_back(mk(1, 3'b100, 9'h040, 32'h55555555, 32'h0, 1, "st_f3_100"));
    vecs.push_back(mk(0, 3'b010, 9'h040, 32'h0, 32'hAAAAAAAA, 0, "lw_040"));
    vecs.push_back(mk(0, 3'b001, 9'h043, 32'h0, 32'h0, 1, "lh_043_mis"));
    vecs.push_back(mk(0, 3'b010, 9'h042, 32'h0, 32'h0, 1, "lw_042_mis"));
    vecs.push_back(mk(0, 3'b011, 9'h040, 32'h0, 32'h0, 1, "ld_f3_011"));
    vecs.push_back(mk(0, 3'b110, 9'h040, 32'h0, 32'h0, 1, "ld_f3_110"));
    vecs.push_back(mk(1, 3'b010, 9'h1FC, 32'hCAFEF00D, 32'h0, 0, "sw_1fc"));
    vecs.push_back(mk(0, 3'b101, 9'h1FE, 32'h0, 32'h0000CAFE, 0, "lhu_1fe"));
    vecs.push_back(mk(0, 3'b010, 9'h1FC, 32'h0, 32'hCAFEF00D, 0, "lw_1fc"));

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    rsp_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'h0);
    chk("reset rsp_err", 32'(rsp_err), 32'd0);

    // Table vectors back to back; every access must take exactly three cycles
    prev_acc = 0;
    foreach (vecs[i]) begin
      send(vecs[i]);
      if (i > 0) chk({vecs[i].name, " throughput"}, 32'(acc_cyc - prev_acc), 32'd3);
      prev_acc = acc_cyc;
      collect(1'b1);
    end

    // Backpressure: response held for 5 cycles while another request waits
    send(mk(1, 3'b010, 9'h060, 32'h13579BDF, 32'h0, 0, "bp_sw"));
    collect(1'b1);
    send(mk(0, 3'b010, 9'h060, 32'h0, 32'h13579BDF, 0, "bp_lw"));
    rsp_ready = 1'b0;
    for (int i = 0; i < 20 && !rsp_valid; i++) begin
      @(posedge clk); #1;
    end
    chk("bp rsp_valid rises", 32'(rsp_valid), 32'd1);
    drive_req(mk(0, 3'b100, 9'h060, 32'h0, 32'h0, 0, "bp_pending"));
    for (int i = 0; i < 5; i++) begin
      chk("bp hold rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp hold rsp_rdata", rsp_rdata, 32'h13579BDF);
      chk("bp hold rsp_err", 32'(rsp_err), 32'd0);
      chk("bp hold req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    collect(1'b0);
    chk("bp req_ready after handshake", 32'(req_ready), 32'd1);
    send(mk(0, 3'b100, 9'h060, 32'h0, 32'h000000DF, 0, "bp_lbu"));
    collect(1'b1);

    // Reset during ACCESS suppresses the store
    send(mk(1, 3'b010, 9'h050, 32'h00000000, 32'h0, 0, "rst_sw0"));
    collect(1'b1);
    drive_req(mk(1, 3'b010, 9'h050, 32'h55555555, 32'h0, 0, "rst_sw5"));
    chk("rst_acc req_ready before", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_acc req_ready", 32'(req_ready), 32'd1);
    chk("rst_acc rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_acc rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_acc rsp_err", 32'(rsp_err), 32'd0);
    @(posedge clk); #1;
    chk("rst_acc no late rsp", 32'(rsp_valid), 32'd0);
    send(mk(0, 3'b010, 9'h050, 32'h0, 32'h00000000, 0, "rst_lw_050"));
    collect(1'b1);

    // Reset during RESP drops the response and beats a concurrent req_valid
    drive_req(mk(0, 3'b010, 9'h010, 32'h0, 32'h0, 0, "rst_resp_lw"));
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_resp rsp_valid before", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    chk("rst_resp rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_resp req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    chk("rst_resp still idle", 32'(rsp_valid), 32'd0);
    send(mk(0, 3'b010, 9'h010, 32'h0, 32'hDEADBEEF, 0, "post_rst_lw_010"));
    collect(1'b1);

    chk("scoreboard drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
